fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch and run-control stage directly upstream of the opcode decoder.
- Holds the program counter and addresses the instruction memory.
- Presents the fetched instruction and its 3-bit opcode to the decoder.
- Generates exec_en, which gates every architectural commit (register write, memory write, PC update).
- Implements run, single-step and sticky halt, using the decoder's halt and branch results fed back from the datapath.

Parameters:
- AW, 4: instruction address width; program space is 2^AW words.
- IW, 12: instruction width; opcode is instr[IW-1:IW-3].
- CW, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset, synchronously deasserted externally.
- run_i  in  1  level; high requests free-running execution.
- step_i  in  1  step request; the rising edge is detected internally.
- restart_i  in  1  pulse; leaves HALTED.
- imem_addr  out  AW  instruction memory address (combinational read memory).
- imem_data  in  IW  instruction word at imem_addr, same cycle.
- instr  out  IW  current instruction, equal to imem_data.
- op  out  3  instr[IW-1:IW-3], sent to the decoder.
- halt_i  in  1  decoder halt for the current instruction.
- branch_taken_i  in  1  decoder branch AND datapath equality.
- branch_target_i  in  AW  absolute branch destination.
- exec_en  out  1  current instruction commits this cycle.
- pc  out  AW  current program counter; imem_addr equals pc.
- halted  out  1  high while in HALTED.
- retired  out  CW  count of committed instructions.

Behaviour:
- Reset (asynchronous, immediate, valid mid-instruction): state=IDLE, pc=0, retired=0, step_q=0. Resulting outputs: exec_en=0, halted=0.
- States are IDLE, RUN, STEP and HALTED. exec_en=1 exactly in RUN and STEP; otherwise 0.
- step_edge = step_i & ~step_q, where step_q is step_i registered every cycle.
- IDLE transitions:
  - run_i=1 goes to RUN.
  - Otherwise, step_edge goes to STEP.
  - run_i takes priority over step_edge.
- RUN: each cycle, one instruction commits.
  - halt_i goes to HALTED.
  - Else run_i=0 goes to IDLE; the instruction in the current cycle still commits.
  - Else stays in RUN.
- STEP: exactly one instruction commits.
  - halt_i goes to HALTED.
  - Otherwise goes to IDLE, regardless of run_i.
- HALTED: sticky.
  - restart_i goes to IDLE with pc=0; retired is kept.
  - run_i and step_edge are ignored.
- PC update, only when exec_en=1:
  - halt_i=1: pc is held. Halt wins over a simultaneous branch.
  - branch_taken_i=1: pc=branch_target_i.
  - Otherwise: pc=pc+1 modulo 2^AW, so pc wraps from 2^AW-1 to 0 without a flag.
- With exec_en=0, pc is held and branch_taken_i and halt_i are don't-care.
- retired increments on every exec_en cycle, including the halting instruction. It saturates at 2^CW-1.
- step_edge occurring in RUN or HALTED is discarded, not queued.
- Latency: combinational from pc to instr/op. Commit and next-PC take effect on the same clock edge. This gives one instruction per cycle in RUN.
- No X on any output after reset. Illegal opcodes pass through unchanged; the decoder owns them.

Decomposition:
- Shared package cpu_pkg holds:
  - OP_W=3 and the opcode constants OP_STORE=000, OP_LOAD=001, OP_ADD=010, OP_BEQ=101, OP_HALT=111. The decoder imports these too.
  - The run-state enum seq_state_t {IDLE, RUN, STEP, HALTED}.
- One natural sub-module, edge_detect: a one-flop rising-edge detector with asynchronous active-low reset, used for step_i. The FSM, PC and counter stay in fetch_sequencer.

Test Plan:
- Reset then run_i=1 with a ROM of ADD at 0..3 and HALT at 4:
  - exec_en is high for 5 cycles and pc follows 0,1,2,3,4.
  - halted=1 with pc held at 4 and retired=5.
- Step: in IDLE, hold step_i high for 3 cycles:
  - exactly one commit; pc goes 0 to 1 and retired=1.
  - A second rising edge gives pc=2.
- Branch: BEQ at address 2 with branch_taken_i=1 and target=9:
  - pc sequence 0,1,2,9.
  - With branch_taken_i=0: 0,1,2,3.
- Simultaneous: halt_i=1 and branch_taken_i=1 with target=7 at pc=5:
  - pc stays 5 and state is HALTED.
  - run_i and step_i are then ignored.
  - restart_i gives IDLE, pc=0 and retired unchanged.
- Wrap and reset: run ADDs from pc=14 with AW=4:
  - pc goes 14,15,0,1.
  - Dropping reset_n mid-cycle at pc=1 immediately gives pc=0, exec_en=0 and retired=0.
- Run stop: drop run_i while pc=3 in RUN:
  - instruction 3 commits and pc becomes 4.
  - The next cycle is IDLE with exec_en=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and the run-control state type.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

   localparam int OP_W = 3;

   // Opcode encodings; the decoder imports the same constants.
   localparam logic [OP_W-1:0] OP_STORE = 3'b000;
   localparam logic [OP_W-1:0] OP_LOAD  = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
   localparam logic [OP_W-1:0] OP_BEQ   = 3'b101;
   localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } seq_state_t;

endpackage

// File: rtl/edge_detect.sv
// One-flop rising-edge detector.
// Latency: rise_o is combinational from sig_i, qualified by the previous-cycle value.
// Backpressure: none.
// Ports: clk, reset_n (async active-low), sig_i (level in), rise_o (high while sig_i rose this cycle).
module edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and run control: PC, imem addressing, exec_en gating, run/step/halt FSM.
// Latency: pc -> instr/op combinational; commit and next PC on the same edge (1 instr/cycle in RUN).
// Backpressure: none; step edges seen outside IDLE are dropped, HALTED is left only via restart_i.
// Ports: clk, reset_n; run_i/step_i/restart_i control; imem_addr/imem_data fetch;
//        instr/op to decoder; halt_i/branch_taken_i/branch_target_i from decoder/datapath;
//        exec_en, pc, halted, retired status.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int AW = 4,
   parameter int IW = 12,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            run_i,
   input  logic            step_i,
   input  logic            restart_i,
   output logic [AW-1:0]   imem_addr,
   input  logic [IW-1:0]   imem_data,
   output logic [IW-1:0]   instr,
   output logic [OP_W-1:0] op,
   input  logic            halt_i,
   input  logic            branch_taken_i,
   input  logic [AW-1:0]   branch_target_i,
   output logic            exec_en,
   output logic [AW-1:0]   pc,
   output logic            halted,
   output logic [CW-1:0]   retired
);

   seq_state_t      state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [CW-1:0]   retired_q, retired_d;
   logic            step_edge;

   edge_detect u_step_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .sig_i   (step_i),
      .rise_o  (step_edge)
   );

   assign exec_en = (state_q == RUN) || (state_q == STEP);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;

      unique case (state_q)
         IDLE: begin
            // run_i has priority over a coincident step edge
            if (run_i) begin
               state_d = RUN;
            end else if (step_edge) begin
               state_d = STEP;
            end
         end
         RUN: begin
            if (halt_i) begin
               state_d = HALTED;
            end else if (!run_i) begin
               state_d = IDLE;
            end
         end
         STEP: begin
            state_d = halt_i ? HALTED : IDLE;
         end
         HALTED: begin
            if (restart_i) begin
               state_d = IDLE;
               pc_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // The halting instruction still commits (and counts) but leaves pc in place,
      // even if the datapath also reports a taken branch.
      if (exec_en) begin
         if (halt_i) begin
            pc_d = pc_q;
         end else if (branch_taken_i) begin
            pc_d = branch_target_i;
         end else begin
            pc_d = pc_q + 1'b1;
         end
         if (retired_q != '1) begin
            retired_d = retired_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = imem_data;
   assign op        = imem_data[IW-1 -: OP_W];
   assign halted    = (state_q == HALTED);
   assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a ROM and decoder stand-in drive the DUT,
// expected commit PCs are queued as stimulus is set up and popped on each exec_en cycle.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   localparam int AW = 4;
   localparam int IW = 12;
   localparam int CW = 16;

   localparam logic [IW-1:0] I_ADD  = {OP_ADD,  9'h000};
   localparam logic [IW-1:0] I_BEQ  = {OP_BEQ,  9'h000};
   localparam logic [IW-1:0] I_HALT = {OP_HALT, 9'h000};

   logic            clk = 1'b0;
   logic            reset_n;
   logic            run_i, step_i, restart_i;
   logic [AW-1:0]   imem_addr;
   logic [IW-1:0]   imem_data;
   logic [IW-1:0]   instr;
   logic [OP_W-1:0] op;
   logic            halt_i, branch_taken_i;
   logic [AW-1:0]   branch_target_i;
   logic            exec_en;
   logic [AW-1:0]   pc;
   logic            halted;
   logic [CW-1:0]   retired;

   logic [IW-1:0]   rom [16];
   logic            br_en;
   logic [AW-1:0]   br_tgt;
   logic [AW-1:0]   exp_q [$];
   int              n_cmp = 0;
   int              n_err = 0;

   always #5 clk = ~clk;

   // Decoder / datapath stand-in
   assign imem_data       = rom[imem_addr];
   assign halt_i          = (op == OP_HALT);
   assign branch_taken_i  = br_en && ((op == OP_BEQ) || (op == OP_HALT));
   assign branch_target_i = br_tgt;

   fetch_sequencer #(.AW(AW), .IW(IW), .CW(CW)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .run_i           (run_i),
      .step_i          (step_i),
      .restart_i       (restart_i),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .instr           (instr),
      .op              (op),
      .halt_i          (halt_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .exec_en         (exec_en),
      .pc              (pc),
      .halted          (halted),
      .retired         (retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_add();
      for (int i = 0; i < 16; i++) rom[i] = I_ADD;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      run_i     = 1'b0;
      step_i    = 1'b0;
      restart_i = 1'b0;
      br_en     = 1'b0;
      br_tgt    = '0;
      tick();
      reset_n   = 1'b1;
   endtask

   task automatic wait_halt(input string tag, input int bound);
      for (int i = 0; i < bound && !halted; i++) tick();
      chk(tag, {31'd0, halted}, 32'd1);
   endtask

   // Commit scoreboard: every exec_en cycle must match the next queued PC.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && exec_en === 1'b1) begin
         chk("sb_commit_expected", {31'd0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            logic [AW-1:0] e;
            logic [IW-1:0] w;
            e = exp_q.pop_front();
            w = rom[e];
            chk("sb_pc", {28'd0, pc}, {28'd0, e});
            chk("sb_imem_addr", {28'd0, imem_addr}, {28'd0, e});
            chk("sb_instr", {20'd0, instr}, {20'd0, w});
            chk("sb_op", {29'd0, op}, {29'd0, w[IW-1 -: OP_W]});
         end
      end
   end

   initial begin
      // ---- reset state
      fill_add();
      rom[4] = I_HALT;
      reset_n = 1'b0; run_i = 1'b0; step_i = 1'b0; restart_i = 1'b0;
      br_en = 1'b0; br_tgt = '0;
      tick();
      tick();
      chk("rst_exec_en", {31'd0, exec_en}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_pc", {28'd0, pc}, 32'd0);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      reset_n = 1'b1;

      // ---- run ADD x4 then HALT
      for (int i = 0; i <= 4; i++) exp_q.push_back(AW'(i));
      run_i = 1'b1;
      wait_halt("run_reach_halt", 20);
      chk("run_pc_held", {28'd0, pc}, 32'd4);
      chk("run_retired", {16'd0, retired}, 32'd5);
      chk("run_exec_off", {31'd0, exec_en}, 32'd0);
      chk("run_sb_drained", exp_q.size(), 32'd0);

      // ---- step: long step_i pulse commits exactly once
      do_reset();
      fill_add();
      exp_q.push_back(AW'(0));
      step_i = 1'b1;
      tick(); tick(); tick();
      step_i = 1'b0;
      tick();
      chk("step1_pc", {28'd0, pc}, 32'd1);
      chk("step1_retired", {16'd0, retired}, 32'd1);
      chk("step1_exec_off", {31'd0, exec_en}, 32'd0);
      exp_q.push_back(AW'(1));
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      tick(); tick();
      chk("step2_pc", {28'd0, pc}, 32'd2);
      chk("step2_retired", {16'd0, retired}, 32'd2);
      chk("step_sb_drained", exp_q.size(), 32'd0);

      // ---- branch taken: 0,1,2 -> 9 (HALT at 9)
      do_reset();
      fill_add();
      rom[2] = I_BEQ;
      rom[9] = I_HALT;
      br_en  = 1'b1;
      br_tgt = 4'd9;
      exp_q.push_back(4'd0); exp_q.push_back(4'd1);
      exp_q.push_back(4'd2); exp_q.push_back(4'd9);
      run_i = 1'b1;
      wait_halt("br_reach_halt", 20);
      chk("br_pc", {28'd0, pc}, 32'd9);
      chk("br_retired", {16'd0, retired}, 32'd4);
      chk("br_sb_drained", exp_q.size(), 32'd0);

      // ---- branch not taken: 0,1,2,3,4 (HALT at 4)
      do_reset();
      rom[4] = I_HALT;
      for (int i = 0; i <= 4; i++) exp_q.push_back(AW'(i));
      run_i = 1'b1;
      wait_halt("nbr_reach_halt", 20);
      chk("nbr_pc", {28'd0, pc}, 32'd4);
      chk("nbr_retired", {16'd0, retired}, 32'd5);
      chk("nbr_sb_drained", exp_q.size(), 32'd0);

      // ---- halt and branch together at pc=5: halt wins, then sticky
      do_reset();
      fill_add();
      rom[5] = I_HALT;
      br_en  = 1'b1;
      br_tgt = 4'd7;
      for (int i = 0; i <= 5; i++) exp_q.push_back(AW'(i));
      run_i = 1'b1;
      wait_halt("hb_reach_halt", 20);
      chk("hb_pc", {28'd0, pc}, 32'd5);
      chk("hb_retired", {16'd0, retired}, 32'd6);
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      tick(); tick();
      chk("hb_sticky_halted", {31'd0, halted}, 32'd1);
      chk("hb_sticky_pc", {28'd0, pc}, 32'd5);
      chk("hb_sticky_retired", {16'd0, retired}, 32'd6);
      chk("hb_sb_drained", exp_q.size(), 32'd0);
      run_i = 1'b0;
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      chk("restart_halted", {31'd0, halted}, 32'd0);
      chk("restart_pc", {28'd0, pc}, 32'd0);
      chk("restart_retired", {16'd0, retired}, 32'd6);
      chk("restart_exec_off", {31'd0, exec_en}, 32'd0);
      tick();
      chk("restart_idle_exec_off", {31'd0, exec_en}, 32'd0);

      // ---- wrap 14,15,0 then async reset mid-cycle at pc=1
      do_reset();
      fill_add();
      for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
      exp_q.push_back(4'd0);
      run_i = 1'b1;
      for (int i = 0; i < 40 && !(pc == 4'd1 && retired == 16'd17); i++) tick();
      chk("wrap_reach_pc1", {28'd0, pc}, 32'd1);
      chk("wrap_retired", {16'd0, retired}, 32'd17);
      chk("wrap_sb_drained", exp_q.size(), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_pc", {28'd0, pc}, 32'd0);
      chk("async_rst_exec_en", {31'd0, exec_en}, 32'd0);
      chk("async_rst_retired", {16'd0, retired}, 32'd0);
      chk("async_rst_halted", {31'd0, halted}, 32'd0);
      run_i = 1'b0;
      tick();
      reset_n = 1'b1;

      // ---- drop run_i while pc=3: instruction 3 still commits
      fill_add();
      for (int i = 0; i <= 3; i++) exp_q.push_back(AW'(i));
      run_i = 1'b1;
      for (int i = 0; i < 20 && pc != 4'd3; i++) tick();
      chk("stop_reach_pc3", {28'd0, pc}, 32'd3);
      chk("stop_exec_at_pc3", {31'd0, exec_en}, 32'd1);
      run_i = 1'b0;
      tick();
      chk("stop_pc", {28'd0, pc}, 32'd4);
      chk("stop_exec_off", {31'd0, exec_en}, 32'd0);
      chk("stop_retired", {16'd0, retired}, 32'd4);
      tick();
      chk("stop_pc_held", {28'd0, pc}, 32'd4);
      chk("stop_idle_exec_off", {31'd0, exec_en}, 32'd0);
      chk("stop_sb_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
